chaos_key_packer: RTL and testbench

Parametrised key-assembly stage that sits behind the chaotic-system core (the x/y/z float state generator) and in front of the key consumers. It discards a configurable number of warm-up samples, packs accepted (x,y,z) samples into NUM_KEYS keys of KEY_W bits, and raises a done flag. It generalises the fixed four-key, 384-bit arrangement in three ways: a valid/ready handshake on the input, an optional XOR whitening of each key against the previous round, and a regenerate request.

---
 rtl/chaos_key_packer.sv | 173 +++++++++++++++++
 tb/tb_chaos_key_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_key_packer.sv
// Key-assembly stage behind the chaotic x/y/z generator.
// It drops WARMUP warm-up samples after reset and packs accepted samples into NUM_KEYS keys
// of KEY_W bits. Within a key, the first sample sits in the MSBs with x highest.
// When a round is started with whiten set, each key is XORed with the same key from the
// previous round. A regen pulse in DONE starts a new round without repeating warm-up.
module chaos_key_packer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned KEY_W    = 384,
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned WARMUP   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         x,
  input  logic [DATA_W-1:0]         y,
  input  logic [DATA_W-1:0]         z,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      whiten,
  input  logic                      regen,
  output logic [NUM_KEYS*KEY_W-1:0] keys,
  output logic                      flag,
  output logic                      busy
);

  localparam int unsigned SampleW = 3 * DATA_W;
  localparam int unsigned SPW     = KEY_W / SampleW;
  localparam int unsigned SampW   = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned KeyW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned WarmW   = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [SampW-1:0] SampLast = SampW'(SPW - 1);
  localparam logic [KeyW-1:0]  KeyLast  = KeyW'(NUM_KEYS - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'((WARMUP > 0) ? WARMUP - 1 : 0);

  if ((KEY_W % SampleW) != 0 || KEY_W < SampleW) begin : g_bad_key_w
    $error("chaos_key_packer: KEY_W must be a non-zero multiple of 3*DATA_W");
  end
  if (NUM_KEYS < 1) begin : g_bad_num_keys
    $error("chaos_key_packer: NUM_KEYS must be at least 1");
  end

  typedef enum logic [1:0] {StWarm, StFill, StDone} state_e;

  // With no warm-up the block comes out of reset already filling.
  localparam state_e ResetSt = (WARMUP > 0) ? StWarm : StFill;

  state_e                    state_q, state_d;
  logic [WarmW-1:0]          warm_cnt_q, warm_cnt_d;
  logic [SampW-1:0]          samp_cnt_q, samp_cnt_d;
  logic [KeyW-1:0]           key_idx_q, key_idx_d;
  logic                      whiten_q, whiten_d;
  logic                      flag_q, flag_d;
  logic [KEY_W-1:0]          shreg_q, shreg_d;
  logic [NUM_KEYS*KEY_W-1:0] keys_q, keys_d;

  logic             accept;
  logic [KEY_W-1:0] pack_val;

  // Shift-register contents including the sample being accepted this cycle.
  if (SPW > 1) begin : g_shift
    assign pack_val = {shreg_q[KEY_W-SampleW-1:0], x, y, z};
  end else begin : g_no_shift
    assign pack_val = {x, y, z};
  end

  assign accept = in_valid & in_ready;
  assign keys   = keys_q;
  assign flag   = flag_q;

  // Ready and busy depend only on state, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StWarm, StFill: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Next-state: warm-up discard, sample packing, key commit and round restart.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    samp_cnt_d = samp_cnt_q;
    key_idx_d  = key_idx_q;
    whiten_d   = whiten_q;
    flag_d     = flag_q;
    shreg_d    = shreg_q;
    keys_d     = keys_q;

    unique case (state_q)
      StWarm: begin
        if (accept) begin
          warm_cnt_d = warm_cnt_q + 1'b1;
          if (warm_cnt_q == WarmLast) begin
            state_d  = StFill;
            whiten_d = whiten;
          end
        end
      end

      StFill: begin
        if (accept) begin
          shreg_d = pack_val;
          if (samp_cnt_q == SampLast) begin
            samp_cnt_d = '0;
            key_idx_d  = key_idx_q + 1'b1;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
              if (key_idx_q == KeyW'(k)) begin
                keys_d[k*KEY_W +: KEY_W] = whiten_q ? (pack_val ^ keys_q[k*KEY_W +: KEY_W])
                                                    : pack_val;
              end
            end
            if (key_idx_q == KeyLast) begin
              key_idx_d = '0;
              state_d   = StDone;
              flag_d    = 1'b1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

      StDone: begin
        // Regen wins over a simultaneous in_valid; in_ready is low here, so nothing is taken.
        if (regen) begin
          state_d    = StFill;
          flag_d     = 1'b0;
          warm_cnt_d = '0;
          samp_cnt_d = '0;
          key_idx_d  = '0;
          whiten_d   = whiten;
        end
      end

      default: begin
        state_d = ResetSt;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ResetSt;
      warm_cnt_q <= '0;
      samp_cnt_q <= '0;
      key_idx_q  <= '0;
      whiten_q   <= 1'b0;
      flag_q     <= 1'b0;
      shreg_q    <= '0;
      keys_q     <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      key_idx_q  <= key_idx_d;
      whiten_q   <= whiten_d;
      flag_q     <= flag_d;
      shreg_q    <= shreg_d;
      keys_q     <= keys_d;
    end
  end

endmodule

// File: tb/tb_chaos_key_packer.sv
// Directed bench for chaos_key_packer.
// DUT a uses WARMUP=2 for the round, whitening, reset and DONE-hold scenarios.
// DUT b uses WARMUP=0 for the distinct-sample packing order.
module tb_chaos_key_packer;

  localparam int unsigned KW = 384;
  localparam int unsigned NK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a signals
  logic                rst_a = 1'b0;
  logic [31:0]         x_a = 32'h3f800000, y_a = 32'h3f800000, z_a = 32'h3f800000;
  logic                valid_a = 1'b0, whiten_a = 1'b0, regen_a = 1'b0;
  logic                ready_a, flag_a, busy_a;
  logic [NK*KW-1:0]    keys_a;

  // DUT b signals
  logic                rst_b = 1'b0;
  logic [31:0]         x_b = '0, y_b = '0, z_b = '0;
  logic                valid_b = 1'b0;
  logic                ready_b, flag_b, busy_b;
  logic [NK*KW-1:0]    keys_b;

  chaos_key_packer #(.DATA_W(32), .KEY_W(KW), .NUM_KEYS(NK), .WARMUP(2)) u_dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .x        (x_a),
    .y        (y_a),
    .z        (z_a),
    .in_valid (valid_a),
    .in_ready (ready_a),
    .whiten   (whiten_a),
    .regen    (regen_a),
    .keys     (keys_a),
    .flag     (flag_a),
    .busy     (busy_a)
  );

  chaos_key_packer #(.DATA_W(32), .KEY_W(KW), .NUM_KEYS(NK), .WARMUP(0)) u_dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .x        (x_b),
    .y        (y_b),
    .z        (z_b),
    .in_valid (valid_b),
    .in_ready (ready_b),
    .whiten   (1'b0),
    .regen    (1'b0),
    .keys     (keys_b),
    .flag     (flag_b),
    .busy     (busy_b)
  );

  int errors = 0;
  int checks = 0;

  logic [KW-1:0] key_one;
  logic [KW-1:0] key_zero;
  logic [KW-1:0] exp_key;

  task automatic check_eq(input string tag, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Feed n accepts into DUT a, optionally toggling in_valid every cycle; bounded by a budget.
  task automatic feed_a(input int n, input bit toggle, output int cycles);
    int acc;
    bit v;
    acc    = 0;
    cycles = 0;
    v      = 1'b1;
    while (acc < n && cycles < 400) begin
      valid_a = v;
      if (v && ready_a) acc++;
      @(posedge clk);
      #1;
      cycles++;
      if (toggle) v = ~v;
    end
    valid_a = 1'b0;
    if (acc < n) check_eq("feed_timeout", KW'(acc), KW'(n));
  endtask

  task automatic reset_a();
    rst_a   = 1'b0;
    valid_a = 1'b0;
    regen_a = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
  endtask

  task automatic check_keys_a(input string tag, input logic [KW-1:0] exp);
    for (int k = 0; k < int'(NK); k++) begin
      check_eq($sformatf("%s_key%0d", tag, k), keys_a[k*KW +: KW], exp);
    end
  endtask

  initial begin
    int cyc;
    key_one  = {12{32'h3f800000}};
    key_zero = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    check_keys_a("reset", key_zero);
    check_eq("reset_flag", KW'(flag_a), KW'(1'b0));
    check_eq("reset_ready", KW'(ready_a), KW'(1'b1));
    check_eq("reset_busy", KW'(busy_a), KW'(1'b1));

    // Constant samples, in_valid held high: 2 warm-up + 16 packed
    feed_a(17, 1'b0, cyc);
    check_eq("t1_flag_at17", KW'(flag_a), KW'(1'b0));
    check_eq("t1_ready_at17", KW'(ready_a), KW'(1'b1));
    check_eq("t1_cycles17", KW'(cyc), KW'(17));
    feed_a(1, 1'b0, cyc);
    check_eq("t1_flag_at18", KW'(flag_a), KW'(1'b1));
    check_eq("t1_ready_done", KW'(ready_a), KW'(1'b0));
    check_eq("t1_busy_done", KW'(busy_a), KW'(1'b0));
    check_keys_a("t1", key_one);

    // Same with in_valid toggling
    reset_a();
    check_eq("t2_flag_reset", KW'(flag_a), KW'(1'b0));
    check_keys_a("t2_reset", key_zero);
    feed_a(18, 1'b1, cyc);
    check_eq("t2_cycles", KW'(cyc), KW'(35));
    check_eq("t2_flag", KW'(flag_a), KW'(1'b1));
    check_keys_a("t2", key_one);

    // Regen with whitening; whiten dropped mid-round must not matter
    whiten_a = 1'b1;
    regen_a  = 1'b1;
    @(posedge clk);
    #1;
    regen_a  = 1'b0;
    whiten_a = 1'b0;
    check_eq("t3_flag_cleared", KW'(flag_a), KW'(1'b0));
    check_eq("t3_busy", KW'(busy_a), KW'(1'b1));
    check_eq("t3_ready", KW'(ready_a), KW'(1'b1));
    check_eq("t3_old_key0", keys_a[0 +: KW], key_one);
    feed_a(15, 1'b0, cyc);
    check_eq("t3_flag_at15", KW'(flag_a), KW'(1'b0));
    check_eq("t3_old_key3", keys_a[3*KW +: KW], key_one);
    feed_a(1, 1'b0, cyc);
    check_eq("t3_flag_at16", KW'(flag_a), KW'(1'b1));
    check_keys_a("t3", key_zero);

    // Reset mid-FILL after 9 packed samples, with in_valid high during reset
    reset_a();
    feed_a(11, 1'b0, cyc);
    check_eq("t5_key0_pre", keys_a[0 +: KW], key_one);
    check_eq("t5_key2_pre", keys_a[2*KW +: KW], key_zero);
    rst_a   = 1'b0;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a   = 1'b1;
    valid_a = 1'b0;
    check_keys_a("t5_after_rst", key_zero);
    check_eq("t5_flag", KW'(flag_a), KW'(1'b0));
    check_eq("t5_busy", KW'(busy_a), KW'(1'b1));
    feed_a(17, 1'b0, cyc);
    check_eq("t5_flag_at17", KW'(flag_a), KW'(1'b0));
    feed_a(1, 1'b0, cyc);
    check_eq("t5_flag_at18", KW'(flag_a), KW'(1'b1));
    check_keys_a("t5", key_one);

    // DONE holds keys against valid traffic; regen+valid drops that sample
    for (int i = 0; i < 20; i++) begin
      valid_a = 1'b1;
      x_a = 32'h1000 + i;
      y_a = 32'h2000 + i;
      z_a = 32'h3000 + i;
      @(posedge clk);
      #1;
    end
    check_keys_a("t6_hold", key_one);
    check_eq("t6_flag_hold", KW'(flag_a), KW'(1'b1));
    check_eq("t6_ready_hold", KW'(ready_a), KW'(1'b0));
    x_a = 32'hdeadbeef;
    y_a = 32'hdeadbeef;
    z_a = 32'hdeadbeef;
    regen_a = 1'b1;
    @(posedge clk);
    #1;
    regen_a = 1'b0;
    valid_a = 1'b0;
    x_a = 32'h3f800000;
    y_a = 32'h3f800000;
    z_a = 32'h3f800000;
    check_eq("t6_flag_regen", KW'(flag_a), KW'(1'b0));
    feed_a(15, 1'b0, cyc);
    check_eq("t6_flag_at15", KW'(flag_a), KW'(1'b0));
    feed_a(1, 1'b0, cyc);
    check_eq("t6_flag_at16", KW'(flag_a), KW'(1'b1));
    check_keys_a("t6", key_one);

    // DUT b: WARMUP=0, distinct samples
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    check_eq("b_reset_ready", KW'(ready_b), KW'(1'b1));
    check_eq("b_reset_busy", KW'(busy_b), KW'(1'b1));
    for (int i = 0; i < 16; i++) begin
      valid_b = 1'b1;
      x_b = 32'(i);
      y_b = 32'(i + 100);
      z_b = 32'(i + 200);
      @(posedge clk);
      #1;
    end
    valid_b = 1'b0;
    check_eq("b_flag", KW'(flag_b), KW'(1'b1));
    check_eq("b_busy", KW'(busy_b), KW'(1'b0));
    check_eq("b_key0", keys_b[0 +: KW],
             {32'd0, 32'd100, 32'd200, 32'd1, 32'd101, 32'd201,
              32'd2, 32'd102, 32'd202, 32'd3, 32'd103, 32'd203});
    check_eq("b_key3_top", KW'(keys_b[3*KW + KW - 96 +: 96]),
             KW'({32'd12, 32'd112, 32'd212}));
    for (int k = 1; k < 4; k++) begin
      exp_key = '0;
      for (int j = 0; j < 4; j++) begin
        exp_key[KW - 96*(j+1) +: 96] = {32'(4*k + j), 32'(4*k + j + 100), 32'(4*k + j + 200)};
      end
      check_eq($sformatf("b_key%0d", k), keys_b[k*KW +: KW], exp_key);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
